// File: rtl/rv32i_boot_loader_pkg.sv
// Shared types and defaults for the RV32I serial boot loader.
// The state enum is used by both the loader FSM and anything that decodes its status.
package rv32i_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        RELEASE,
        RUN,
        ERROR
    } boot_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         RST_HOLD_DEF  = 4;

endpackage

// File: rtl/rv32i_boot_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// word_valid pulses combinationally with the 4th byte, so the word is ready on that same transfer.
module rv32i_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [31:0] shift_reg;

    // Each new byte enters at the top, so after four bytes the first one sits in [7:0].
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (byte_valid) begin
            byte_cnt  <= byte_cnt + 2'd1;
            shift_reg <= {byte_data, shift_reg[31:8]};
        end
    end

    assign word_valid = byte_valid && (byte_cnt == 2'd3);
    assign word       = {byte_data, shift_reg[31:8]};

endmodule

// File: rtl/rv32i_boot_loader.sv
// Framed serial program loader: SYNC, LEN (words, LE), payload words (LE bytes), 8-bit sum.
// Writes IMEM word by word and holds the core in reset until the checksum verifies.
module rv32i_boot_loader
    import rv32i_boot_pkg::*;
#(
    parameter int         IMEM_DEPTH = 2048,
    parameter int         ADDR_W     = 11,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int         RST_HOLD   = RST_HOLD_DEF
) (
    input  logic              pad_clk,
    input  logic              pad_rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    boot_state_t       state;
    boot_state_t       next_state;

    logic              xfer;
    logic              is_sync;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       full_len;
    logic              len_bad;
    logic [ADDR_W-1:0] word_idx;
    logic              last_word;
    logic [7:0]        csum;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic              asm_clear;
    logic              asm_valid;
    logic              word_valid;
    logic [31:0]       word;

    assign xfer      = rx_valid && rx_ready;
    assign is_sync   = (rx_data == SYNC_BYTE);
    assign full_len  = {rx_data, len_lo};
    assign len_bad   = (full_len == 16'd0) || (full_len > 16'(IMEM_DEPTH));
    assign last_word = ({{(16 - ADDR_W){1'b0}}, word_idx} == (len - 16'd1));
    assign hold_done = (hold_cnt == HOLD_W'(RST_HOLD - 1));

    // The assembler restarts at every fresh payload and whenever a resync abandons a bad frame.
    assign asm_clear = xfer && (((state == LEN1) && !len_bad) || ((state == ERROR) && is_sync));
    assign asm_valid = xfer && (state == DATA);

    rv32i_word_assembler u_word_assembler (
        .clk        (pad_clk),
        .rst_n      (pad_rst_n),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge pad_clk) begin
        if (!pad_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rx_ready   = 1'b1;
        load_busy  = 1'b0;
        load_err   = 1'b0;
        case (state)
            IDLE: begin
                if (xfer && is_sync) next_state = LEN0;
            end
            LEN0: begin
                load_busy = 1'b1;
                if (xfer) next_state = LEN1;
            end
            LEN1: begin
                load_busy = 1'b1;
                if (xfer) next_state = len_bad ? ERROR : DATA;
            end
            DATA: begin
                load_busy = 1'b1;
                if (word_valid && last_word) next_state = CSUM;
            end
            CSUM: begin
                load_busy = 1'b1;
                if (xfer) next_state = (rx_data == csum) ? RELEASE : ERROR;
            end
            RELEASE: begin
                load_busy = 1'b1;
                rx_ready  = 1'b0;
                if (hold_done) next_state = RUN;
            end
            RUN: begin
                rx_ready = 1'b0;
            end
            ERROR: begin
                load_err = 1'b1;
                if (xfer && is_sync) next_state = LEN0;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The IMEM port is a registered one-cycle pulse; it never back-pressures the byte stream.
    always_ff @(posedge pad_clk) begin
        if (!pad_rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            word_idx   <= '0;
            csum       <= '0;
            hold_cnt   <= '0;
        end else begin
            imem_we    <= 1'b0;
            core_rst_n <= (next_state == RUN);
            load_done  <= (next_state == RUN);

            if (xfer && (state == LEN0)) begin
                len_lo <= rx_data;
            end

            if (asm_clear) begin
                word_idx <= '0;
                csum     <= '0;
                if (state == LEN1) len <= full_len;
            end

            if (asm_valid) begin
                csum <= csum + rx_data;
            end

            // Holding the index on the final word keeps the address from ever wrapping past LEN-1.
            if (word_valid) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx;
                imem_wdata <= word;
                if (!last_word) word_idx <= word_idx + 1'b1;
            end

            if (xfer && (state == CSUM)) begin
                hold_cnt <= '0;
            end else if (state == RELEASE) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule
